vga_grid_capture: RTL
=====================

VGA_GRID_CAPTURE -- requirements
Module: vga_grid_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 800, meaning clocks per line.
REQ-002 SHALL have parameter V_LINES, default 521, meaning lines per frame.
REQ-003 SHALL have parameter H_BP, default 144, meaning first active-region column count.
REQ-004 SHALL have parameter V_BP, default 31, meaning first active line.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive good frames needed to lock.
REQ-006 Clock  input  1  single clock, pixel rate; all logic on rising edge.
REQ-007 ResetN  input  1  synchronous, active-low reset.
REQ-008 RGB  input  8  pixel colour, same encoding as COLOR_* constants.
REQ-009 HSync  input  1  horizontal sync, active low.
REQ-010 VSync  input  1  vertical sync, active low.
REQ-011 Blocks  output  BITS_PER_BLOCK*GRID_HEIGHT*GRID_WIDTH, ascending [0:N-1]  recovered grid; block (r,c) LSB at bit 2*(r*GRID_WIDTH+c), MSB at that index +1.
REQ-012 Locked  output  1  timing lock achieved.
REQ-013 FrameDone  output  1  one-cycle pulse when Blocks updated.
REQ-014 ColorError  output  1  last published frame contained an unrecognised colour.

Function
REQ-015 RGB, HSync and VSync SHALL be registered once; all decoding uses registered copies.
REQ-016 HSync fall = registered HSync low while previous registered sample high; hCnt SHALL be 0 on that cycle and increment each cycle after, saturating at 1023.
REQ-017 On HSync fall, vCnt SHALL become 0 if VSync fall occurs the same cycle, else vCnt+1, saturating at 1023.
REQ-018 hCnt therefore equals the transmitter pixel column of the sample; vCnt equals its line.
REQ-019 Sample point for block (r,c): hCnt == H_BP + c*BLOCK_WIDTH + BLOCK_WIDTH/2 and vCnt == V_BP + r*BLOCK_HEIGHT + BLOCK_HEIGHT/2.
REQ-020 At a sample point, RGB SHALL map COLOR_EMPTY/SNAKE/FOOD/WALL to BLOCK_EMPTY/SNAKE/FOOD/WALL, written to a shadow grid.
REQ-021 Unmatched colour: shadow entry = BLOCK_EMPTY; per-frame error flag set.
REQ-022 Lock FSM states: UNLOCKED, CHECK, LOCKED.
REQ-023 Line check on each HSync fall: hCnt at that moment (pre-clear) == H_PIXELS-1 is good; frame check on each VSync fall: vCnt pre-clear == V_LINES-1 is good.
REQ-024 UNLOCKED -> CHECK on first VSync fall, good-frame count=0.
REQ-025 CHECK: each good frame with all lines good increments count; count reaching LOCK_FRAMES -> LOCKED; any bad line or frame -> UNLOCKED.
REQ-026 LOCKED: any bad line or frame -> UNLOCKED same cycle; Locked deasserts next cycle.
REQ-027 On VSync fall while in LOCKED (no error this cycle), shadow SHALL copy to Blocks, ColorError <= frame error flag, FrameDone pulses for exactly one cycle; error flag then clears.
REQ-028 Frames ending in UNLOCKED or CHECK SHALL NOT update Blocks or pulse FrameDone; Blocks holds last published value.
REQ-029 First frame after entering LOCKED is published only at the following VSync fall (needs a complete locked frame).
REQ-030 Latency: FrameDone asserts 2 cycles after VSync input falls.

Reset
REQ-031 ResetN low at a rising edge SHALL set Blocks all-zero (BLOCK_EMPTY), Locked=0, FrameDone=0, ColorError=0, FSM=UNLOCKED, counters=0, shadow cleared, sync registers=1.
REQ-032 Reset mid-frame SHALL discard partial frame; relock requires LOCK_FRAMES fresh frames.

Structure
REQ-033 BITS_PER_BLOCK, GRID_WIDTH, GRID_HEIGHT, BLOCK_WIDTH, BLOCK_HEIGHT, BLOCK_* codes and COLOR_* values SHALL come from the shared Constants.v only.
REQ-034 Colour-to-block lookup SHALL be sub-module vga_color_decode (combinational: RGB in, code and valid out).

Verification
REQ-035 Drive loopback from display controller with checkerboard of SNAKE/FOOD, reset released -> Locked=1 after 2 frames, FrameDone on frame 4 with Blocks equal to source, ColorError=0.
REQ-036 Locked loop, inject RGB 8'hFF at block (3,5) sample point -> that block reads BLOCK_EMPTY, ColorError=1 on next publish, 0 on following clean frame.
REQ-037 Locked, shorten one line to 799 clocks -> Locked=0 next cycle, no FrameDone that frame, Blocks unchanged.
REQ-038 ResetN low for 1 cycle mid-frame at line 200 -> all outputs 0 next cycle; FrameDone not seen until 2 good frames plus one publish frame.
REQ-039 Change source grid one frame after lock -> Blocks changes exactly on the next FrameDone pulse, pulse width 1 cycle.

Source files
------------

// File: rtl/vga_grid_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_grid_capture_pkg
// Description : Shared game-grid geometry, block codes, colour values and the
//               lock-FSM state type used by the VGA grid capture block.
//               The display controller encodes with the same constants, so
//               capture and generation stay in step.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_grid_capture_pkg;

    // Grid geometry (blocks and pixels per block)
    localparam int BITS_PER_BLOCK = 2;
    localparam int GRID_WIDTH     = 8;
    localparam int GRID_HEIGHT    = 6;
    localparam int BLOCK_WIDTH    = 4;
    localparam int BLOCK_HEIGHT   = 2;
    localparam int NUM_BLOCKS     = GRID_WIDTH * GRID_HEIGHT;
    localparam int BLOCKS_W       = BITS_PER_BLOCK * NUM_BLOCKS;

    // Block codes
    localparam logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY = 2'd0;
    localparam logic [BITS_PER_BLOCK-1:0] BLOCK_SNAKE = 2'd1;
    localparam logic [BITS_PER_BLOCK-1:0] BLOCK_FOOD  = 2'd2;
    localparam logic [BITS_PER_BLOCK-1:0] BLOCK_WALL  = 2'd3;

    // 8-bit RRRGGGBB colours emitted by the display controller
    localparam logic [7:0] COLOR_EMPTY = 8'h00;
    localparam logic [7:0] COLOR_SNAKE = 8'h1C;
    localparam logic [7:0] COLOR_FOOD  = 8'hE0;
    localparam logic [7:0] COLOR_WALL  = 8'h92;

    // Pixel/line counters
    localparam int                CNT_W   = 10;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_grid_capture_color.sv
`default_nettype none
// ============================================================================
// Module      : vga_color_decode
// Description : Combinational colour-to-block lookup.
//               i_rgb   : 8-bit pixel colour
//               o_code  : block code (BLOCK_EMPTY when colour is unknown)
//               o_valid : 1 when i_rgb matches one of the known colours
// Revision    : 1.0 - initial release
// ============================================================================
module vga_color_decode
    import vga_grid_capture_pkg::*;
(
    input  logic [7:0]                i_rgb,
    output logic [BITS_PER_BLOCK-1:0] o_code,
    output logic                      o_valid
);

    always_comb begin
        o_code  = BLOCK_EMPTY;
        o_valid = 1'b1;
        case (i_rgb)
            COLOR_EMPTY: o_code = BLOCK_EMPTY;
            COLOR_SNAKE: o_code = BLOCK_SNAKE;
            COLOR_FOOD:  o_code = BLOCK_FOOD;
            COLOR_WALL:  o_code = BLOCK_WALL;
            default:     o_valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vga_grid_capture.sv
`default_nettype none
// ============================================================================
// Module      : vga_grid_capture
// Description : Recovers the game grid from a looped-back VGA stream.
//               Locks onto line/frame timing, samples the centre pixel of
//               every block and publishes a whole grid once per locked frame.
// Ports       : Clock      - pixel clock, rising edge
//               ResetN     - synchronous active-low reset
//               RGB        - pixel colour
//               HSync      - horizontal sync, active low
//               VSync      - vertical sync, active low
//               Blocks     - published grid, block (r,c) at bits 2*(r*W+c)+{0,1}
//               Locked     - timing lock achieved
//               FrameDone  - one-cycle pulse when Blocks is updated
//               ColorError - published frame held an unrecognised colour
// Revision    : 1.0 - initial release
// ============================================================================
module vga_grid_capture
    import vga_grid_capture_pkg::*;
#(
    parameter int H_PIXELS    = 800,
    parameter int V_LINES     = 521,
    parameter int H_BP        = 144,
    parameter int V_BP        = 31,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic [7:0]          RGB,
    input  logic                HSync,
    input  logic                VSync,
    output logic [0:BLOCKS_W-1] Blocks,
    output logic                Locked,
    output logic                FrameDone,
    output logic                ColorError
);

    // Input registers and edge history
    logic [7:0]       r_rgb;
    logic             r_hs, r_vs, r_hs_d, r_vs_d;
    logic [CNT_W-1:0] r_hcnt, r_vcnt;
    logic             r_frame_err;
    logic [BITS_PER_BLOCK-1:0] r_shadow [NUM_BLOCKS];
    lock_state_t      r_state;
    logic [CNT_W-1:0] r_good_cnt;

    logic                      w_hs_fall, w_vs_fall;
    logic [CNT_W-1:0]          w_hcnt, w_vcnt;
    logic                      w_line_bad, w_frame_bad;
    logic [GRID_WIDTH-1:0]     w_col_hit;
    logic [GRID_HEIGHT-1:0]    w_row_hit;
    logic                      w_sample_hit;
    logic [BITS_PER_BLOCK-1:0] w_code;
    logic                      w_valid;

    assign w_hs_fall = r_hs_d & ~r_hs;
    assign w_vs_fall = r_vs_d & ~r_vs;

    // w_hcnt/w_vcnt give the transmitter column/line of the sample now in
    // r_rgb; r_hcnt/r_vcnt hold the previous sample's position, which is the
    // "pre-clear" value used for the line and frame length checks.
    assign w_hcnt = w_hs_fall ? '0 :
                    (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CNT_W'(1);
    assign w_vcnt = !w_hs_fall ? r_vcnt :
                    w_vs_fall ? '0 :
                    (r_vcnt == CNT_MAX) ? r_vcnt : r_vcnt + CNT_W'(1);

    assign w_line_bad  = w_hs_fall & (r_hcnt != CNT_W'(H_PIXELS - 1));
    assign w_frame_bad = w_vs_fall & (r_vcnt != CNT_W'(V_LINES - 1));

    // Block-centre detection, rows and columns independently
    always_comb begin
        w_col_hit = '0;
        w_row_hit = '0;
        for (int c = 0; c < GRID_WIDTH; c++)
            w_col_hit[c] = (w_hcnt == CNT_W'(H_BP + c * BLOCK_WIDTH + BLOCK_WIDTH / 2));
        for (int r = 0; r < GRID_HEIGHT; r++)
            w_row_hit[r] = (w_vcnt == CNT_W'(V_BP + r * BLOCK_HEIGHT + BLOCK_HEIGHT / 2));
    end

    assign w_sample_hit = (|w_col_hit) & (|w_row_hit);

    vga_color_decode u_color_decode (
        .i_rgb   (r_rgb),
        .o_code  (w_code),
        .o_valid (w_valid)
    );

    // Input capture, counters, shadow grid and per-frame colour error
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_rgb       <= '0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_hs_d      <= 1'b1;
            r_vs_d      <= 1'b1;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NUM_BLOCKS; i++)
                r_shadow[i] <= BLOCK_EMPTY;
        end else begin
            r_rgb  <= RGB;
            r_hs   <= HSync;
            r_vs   <= VSync;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
            r_hcnt <= w_hcnt;
            r_vcnt <= w_vcnt;
            // Flag restarts at each frame boundary; its pre-clear value is
            // what gets published alongside the grid.
            r_frame_err <= w_vs_fall ? 1'b0 : (r_frame_err | (w_sample_hit & ~w_valid));
            for (int r = 0; r < GRID_HEIGHT; r++)
                for (int c = 0; c < GRID_WIDTH; c++)
                    if (w_row_hit[r] && w_col_hit[c])
                        r_shadow[r * GRID_WIDTH + c] <= w_code;
        end
    end

    // Lock FSM and published outputs
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state    <= ST_UNLOCKED;
            r_good_cnt <= '0;
            Locked     <= 1'b0;
            FrameDone  <= 1'b0;
            ColorError <= 1'b0;
            Blocks     <= '0;
        end else begin
            FrameDone <= 1'b0;
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_vs_fall) begin
                        r_state    <= ST_CHECK;
                        r_good_cnt <= '0;
                    end
                end
                ST_CHECK: begin
                    if (w_line_bad || w_frame_bad) begin
                        r_state <= ST_UNLOCKED;
                    end else if (w_vs_fall) begin
                        if (r_good_cnt == CNT_W'(LOCK_FRAMES - 1)) begin
                            r_state <= ST_LOCKED;
                            Locked  <= 1'b1;
                        end else begin
                            r_good_cnt <= r_good_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_line_bad || w_frame_bad) begin
                        r_state <= ST_UNLOCKED;
                        Locked  <= 1'b0;
                    end else if (w_vs_fall) begin
                        // The frame that just ended was fully sampled while locked
                        for (int i = 0; i < NUM_BLOCKS; i++)
                            for (int b = 0; b < BITS_PER_BLOCK; b++)
                                Blocks[BITS_PER_BLOCK * i + b] <= r_shadow[i][b];
                        ColorError <= r_frame_err;
                        FrameDone  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_UNLOCKED;
                    Locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
